// File: rtl/sdram_cmd_responder.sv
// -----------------------------------------------------------------------------
// sdram_cmd_responder
//   Device-side model of a single x16 SDRAM chip. Decodes the CS#/RAS#/CAS#/WE#
//   command bus, tracks per-bank row state, holds the mode register (BL, CL)
//   and services sequential bursts into a small on-chip array addressed by
//   {bank, row, column}.
//
//   Optional build macro: SDRAM_TIMING_CHECK_EN
//     defined   - per-bank TRCD/TRP counters plus a TRFC counter flag
//                 violations on err_timing (the command still executes).
//     undefined - no counters; err_timing is tied low.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   cke              clock enable; low freezes every state element
//   cs_n/ras_n/cas_n/we_n, ba, addr   command bus (A10 = AP / precharge-all)
//   dqm              byte mask (bit0 = dq[7:0], bit1 = dq[15:8])
//   dq_in            write data
//   dq_out, dq_oe    registered read data and its valid / drive enable
//   err_cmd          one-cycle pulse on an illegal command
//   err_timing       one-cycle pulse on a timing violation
//
// Read data is valid-only: dq_out is meaningful exactly in cycles where
// dq_oe = 1; the controller cannot stall it, so there is no ready signal.
// -----------------------------------------------------------------------------
module sdram_cmd_responder #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 5,
  parameter int TRCD     = 3,
  parameter int TRP      = 2,
  parameter int TRFC     = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [1:0]  ba,
  input  logic [12:0] addr,
  input  logic [1:0]  dqm,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        err_cmd,
  output logic        err_timing
);

  localparam int MEM_AW    = 2 + ROW_BITS + COL_BITS;
  localparam int MEM_DEPTH = 1 << MEM_AW;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
    CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
  } cmd_t;

  typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_t;
  typedef enum logic [1:0] {GEN_IDLE, GEN_WR, GEN_RD} gen_state_t;

  // ---------------------------------------------------------------- decode
  cmd_t cmd;
  logic cmd_en;
  logic is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_bst;
  logic any_active, sel_active, lm_ok, rw_ok, start_rd, start_wr, err_cmd_next;

  bank_state_t             bank_state [4];
  logic [ROW_BITS-1:0]     bank_row   [4];
  logic                    mode_valid;
  logic [1:0]              bl_code;
  logic                    cl3;
  logic [2:0]              bl_last;

  assign cmd_en = cke & ~cs_n;
  assign cmd    = cmd_t'({ras_n, cas_n, we_n});

  always_comb begin
    is_act = cmd_en && (cmd == CMD_ACT);
    is_rd  = cmd_en && (cmd == CMD_RD);
    is_wr  = cmd_en && (cmd == CMD_WR);
    is_pre = cmd_en && (cmd == CMD_PRE);
    is_ref = cmd_en && (cmd == CMD_REF);
    is_lmr = cmd_en && (cmd == CMD_LMR);
    is_bst = cmd_en && (cmd == CMD_BST);
    any_active = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (bank_state[b] == BANK_ACTIVE) any_active = 1'b1;
    end
    sel_active = (bank_state[ba] == BANK_ACTIVE);
    // BL codes 0..3 only (addr[2] = 0), sequential only, CL 2 or 3.
    lm_ok = !any_active && !addr[2] && !addr[3] &&
            ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3));
    rw_ok    = mode_valid && sel_active;
    start_rd = is_rd && rw_ok;
    start_wr = is_wr && rw_ok;
    err_cmd_next = (is_act && sel_active) ||
                   ((is_rd || is_wr) && !rw_ok) ||
                   (is_lmr && !lm_ok) ||
                   (is_ref && any_active);
  end

  // BL-1 doubles as the wrap mask for the column offset.
  always_comb begin
    case (bl_code)
      2'd0:    bl_last = 3'd0;
      2'd1:    bl_last = 3'd1;
      2'd2:    bl_last = 3'd3;
      default: bl_last = 3'd7;
    endcase
  end

  // ------------------------------------------------------- burst generator
  gen_state_t           gen_state, gen_state_next;
  logic [2:0]           gen_k, gen_k_next;
  logic [1:0]           gen_ba;
  logic [COL_BITS-1:0]  gen_col;
  logic                 gen_ap;

  logic                 beat_en, beat_rd, beat_ap, beat_last, gen_abort;
  logic [1:0]           beat_ba;
  logic [2:0]           beat_k;
  logic [COL_BITS-1:0]  beat_base, beat_col, bl_mask;
  logic [MEM_AW-1:0]    beat_addr;
  logic [3:0]           ap_clr;

  always_comb begin
    gen_state_next = gen_state;
    gen_k_next     = gen_k;
    beat_en        = 1'b0;
    beat_rd        = 1'b0;
    beat_ba        = gen_ba;
    beat_base      = gen_col;
    beat_k         = gen_k;
    beat_ap        = gen_ap;
    gen_abort      = 1'b0;
    if (start_rd || start_wr) begin
      // Beat 0 is serviced on the command edge itself.
      gen_abort      = (gen_state != GEN_IDLE);
      beat_en        = 1'b1;
      beat_rd        = start_rd;
      beat_ba        = ba;
      beat_base      = addr[COL_BITS-1:0];
      beat_k         = 3'd0;
      beat_ap        = addr[10];
      gen_k_next     = 3'd1;
      if (bl_last == 3'd0)  gen_state_next = GEN_IDLE;
      else if (start_rd)    gen_state_next = GEN_RD;
      else                  gen_state_next = GEN_WR;
    end else if (cke && (gen_state != GEN_IDLE)) begin
      if (is_bst || (is_pre && (addr[10] || (ba == gen_ba)))) begin
        gen_abort      = 1'b1;
        gen_state_next = GEN_IDLE;
      end else begin
        beat_en    = 1'b1;
        beat_rd    = (gen_state == GEN_RD);
        gen_k_next = gen_k + 3'd1;
        if (gen_k == bl_last) gen_state_next = GEN_IDLE;
      end
    end
  end

  always_comb begin
    bl_mask   = COL_BITS'(bl_last);
    beat_last = beat_en && (beat_k == bl_last);
    // Sequential wrap inside the BL-aligned block.
    beat_col  = (beat_base & ~bl_mask) | ((beat_base + COL_BITS'(beat_k)) & bl_mask);
    beat_addr = {beat_ba, bank_row[beat_ba], beat_col};
    // Auto-precharge: the bank idles on its last beat, or when its burst is cut short.
    ap_clr = 4'b0000;
    if (beat_last && beat_ap)  ap_clr[beat_ba] = 1'b1;
    if (gen_abort && gen_ap)   ap_clr[gen_ba]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gen_state <= GEN_IDLE;
      gen_k     <= 3'd0;
      gen_ba    <= 2'd0;
      gen_col   <= '0;
      gen_ap    <= 1'b0;
    end else begin
      gen_state <= gen_state_next;
      gen_k     <= gen_k_next;
      if (start_rd || start_wr) begin
        gen_ba  <= ba;
        gen_col <= addr[COL_BITS-1:0];
        gen_ap  <= addr[10];
      end
    end
  end

  // ------------------------------------------------- banks, mode, errors
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        bank_state[b] <= BANK_IDLE;
        bank_row[b]   <= '0;
      end
      mode_valid <= 1'b0;
      bl_code    <= 2'd0;
      cl3        <= 1'b0;
      err_cmd    <= 1'b0;
    end else begin
      err_cmd <= err_cmd_next;
      for (int b = 0; b < 4; b++) begin
        if (ap_clr[b]) bank_state[b] <= BANK_IDLE;
        if (is_pre && (addr[10] || (ba == 2'(b)))) bank_state[b] <= BANK_IDLE;
      end
      if (is_act && !sel_active) begin
        bank_state[ba] <= BANK_ACTIVE;
        bank_row[ba]   <= addr[ROW_BITS-1:0];
      end
      if (is_lmr && lm_ok) begin
        mode_valid <= 1'b1;
        bl_code    <= addr[1:0];
        cl3        <= addr[4];
      end
    end
  end

  // ------------------------------------------------------- storage array
  logic [15:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst && beat_en && !beat_rd) begin
      if (!dqm[0]) mem[beat_addr][7:0]  <= dq_in[7:0];
      if (!dqm[1]) mem[beat_addr][15:8] <= dq_in[15:8];
    end
  end

  // ------------------------------------------ read delay line and output
  // Stage 0 is loaded on the beat edge; the output register reads stage CL-2,
  // so data launched at edge N is on dq_out after edge N+CL-1.
  logic [1:0]        dl_v;
  logic [MEM_AW-1:0] dl_a [2];
  logic [1:0]        dqm_q1, dqm_q2;
  logic              tap_v;
  logic [MEM_AW-1:0] tap_a;

  assign tap_v = cl3 ? dl_v[1] : dl_v[0];
  assign tap_a = cl3 ? dl_a[1] : dl_a[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_v    <= 2'b00;
      dl_a[0] <= '0;
      dl_a[1] <= '0;
      dqm_q1  <= 2'b00;
      dqm_q2  <= 2'b00;
      dq_oe   <= 1'b0;
      dq_out  <= 16'h0000;
    end else if (cke) begin
      dqm_q1 <= dqm;
      dqm_q2 <= dqm_q1;
      if (start_wr) begin
        dl_v  <= 2'b00;
        dq_oe <= 1'b0;
      end else begin
        dl_v[0] <= beat_en && beat_rd;
        dl_a[0] <= beat_addr;
        dl_v[1] <= dl_v[0];
        dl_a[1] <= dl_a[0];
        // Read DQM latency 2: dqm from two enabled edges ago masks this beat.
        dq_oe   <= tap_v && !(|dqm_q2);
        if (tap_v) dq_out <= mem[tap_a];
      end
    end
  end

  // ------------------------------------------------------ timing checker
`ifdef SDRAM_TIMING_CHECK_EN
  localparam int TRCD_W = $clog2(TRCD + 1);
  localparam int TRP_W  = $clog2(TRP + 1);
  localparam int TRFC_W = $clog2(TRFC + 1);

  logic [TRCD_W-1:0] trcd_cnt [4];
  logic [TRP_W-1:0]  trp_cnt  [4];
  logic [TRFC_W-1:0] trfc_cnt;
  logic              timing_viol;

  always_comb begin
    timing_viol = 1'b0;
    if ((is_rd || is_wr) && (trcd_cnt[ba] != '0))           timing_viol = 1'b1;
    if (is_act && (trp_cnt[ba] != '0))                      timing_viol = 1'b1;
    if (cmd_en && (cmd != CMD_NOP) && (trfc_cnt != '0))     timing_viol = 1'b1;
  end

  // Counters hold "edges still to wait"; loading N-1 makes edge +N legal.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        trcd_cnt[b] <= '0;
        trp_cnt[b]  <= '0;
      end
      trfc_cnt   <= '0;
      err_timing <= 1'b0;
    end else begin
      err_timing <= timing_viol;
      if (cke) begin
        for (int b = 0; b < 4; b++) begin
          if (trcd_cnt[b] != '0) trcd_cnt[b] <= trcd_cnt[b] - 1'b1;
          if (trp_cnt[b] != '0)  trp_cnt[b]  <= trp_cnt[b] - 1'b1;
          if (ap_clr[b] || (is_pre && (addr[10] || (ba == 2'(b)))))
            trp_cnt[b] <= TRP_W'(TRP - 1);
        end
        if (trfc_cnt != '0) trfc_cnt <= trfc_cnt - 1'b1;
        if (is_act && !sel_active) trcd_cnt[ba] <= TRCD_W'(TRCD - 1);
        if (is_ref && !any_active) trfc_cnt <= TRFC_W'(TRFC - 1);
      end
    end
  end
`else
  assign err_timing = 1'b0;
`endif

  // Upper address bits are not stored by this small array.
  logic unused_ok;
  assign unused_ok = ^addr;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// -----------------------------------------------------------------------------
// tb_sdram_cmd_responder
//   Directed bench for sdram_cmd_responder. Inputs change on the falling edge;
//   outputs are sampled on the falling edge after the rising edge they follow.
// -----------------------------------------------------------------------------
module tb_sdram_cmd_responder;

  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_NOP = 3'b111;

`ifdef SDRAM_TIMING_CHECK_EN
  localparam logic TIMING_EN = 1'b1;
`else
  localparam logic TIMING_EN = 1'b0;
`endif

  // ------------------------------------------------------ clock and reset
  logic        clk = 1'b0;
  logic        rst, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba, dqm;
  logic [12:0] addr;
  logic [15:0] dq_in, dq_out;
  logic        dq_oe, err_cmd, err_timing;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_cmd_responder dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr), .dqm(dqm),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .err_cmd(err_cmd),
    .err_timing(err_timing)
  );

  // ------------------------------------------------------- driver tasks
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba   = b;
    addr = a;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic nops(input int n);
    drive(C_NOP, 2'd0, 13'h0);
    repeat (n) step();
  endtask

  // WRITE burst of four beats; optionally issues ACTIVE to the same bank on
  // the last beat edge (the bank must still be ACTIVE then).
  task automatic write_burst(input logic [1:0] b, input logic [4:0] col, input logic ap,
                             input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3,
                             input logic probe_act);
    logic [15:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    drive(C_WR, b, {2'b00, ap, 5'b00000, col});
    dq_in = d[0];
    step();
    check("wr_err_cmd", err_cmd, 16'h0);
    for (int k = 1; k < 4; k++) begin
      if (probe_act && k == 3) drive(C_ACT, b, 13'h0);
      else                     drive(C_NOP, 2'd0, 13'h0);
      dq_in = d[k];
      step();
    end
    if (probe_act) check("act_during_last_beat", err_cmd, 16'h1);
    drive(C_NOP, 2'd0, 13'h0);
    dq_in = 16'h0;
  endtask

  // READ of four beats with CL = 3: beat k is visible after edge N+2+k.
  task automatic read_burst(input logic [1:0] b, input logic [4:0] col, input logic ap,
                            input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3,
                            input logic mask1, input logic exp_terr);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    drive(C_RD, b, {2'b00, ap, 5'b00000, col});
    step();
    check("rd_err_cmd", err_cmd, 16'h0);
    check("rd_err_timing", err_timing, {15'h0, exp_terr});
    check("rd_oe_edge_n", dq_oe, 16'h0);
    drive(C_NOP, 2'd0, 13'h0);
    dqm = mask1 ? 2'b01 : 2'b00;
    step();
    dqm = 2'b00;
    check("rd_oe_edge_n1", dq_oe, 16'h0);
    check("rd_err_timing_clear", err_timing, 16'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      if (mask1 && k == 1) begin
        check("rd_oe_masked_beat", dq_oe, 16'h0);
      end else begin
        check($sformatf("rd_oe_beat%0d", k), dq_oe, 16'h1);
        check($sformatf("rd_data_beat%0d", k), dq_out, e[k]);
      end
    end
    step();
    check("rd_oe_after_burst", dq_oe, 16'h0);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    rst = 1'b1; cke = 1'b1; dqm = 2'b00; dq_in = 16'h0;
    drive(C_NOP, 2'd0, 13'h0);
    step();
    step();
    check("reset_dq_out", dq_out, 16'h0);
    check("reset_dq_oe", dq_oe, 16'h0);
    check("reset_err_cmd", err_cmd, 16'h0);
    check("reset_err_timing", err_timing, 16'h0);
    rst = 1'b0;

    // READ before any LOAD MODE is illegal; the pulse lasts one cycle.
    drive(C_RD, 2'd0, 13'h0);
    step();
    check("read_before_lmr", err_cmd, 16'h1);
    nops(1);
    check("read_before_lmr_pulse_end", err_cmd, 16'h0);

    // Init sequence.
    nops(10);
    drive(C_PRE, 2'd0, 13'h400);
    step();
    check("pre_all_err", err_cmd, 16'h0);
    nops(4);
    drive(C_REF, 2'd0, 13'h0);
    step();
    check("ref1_err", err_cmd, 16'h0);
    nops(9);
    drive(C_REF, 2'd0, 13'h0);
    step();
    check("ref2_err", err_cmd, 16'h0);
    nops(9);
    drive(C_LMR, 2'd0, 13'd53);       // BL code 5
    step();
    check("lmr_bad_bl", err_cmd, 16'h1);
    drive(C_LMR, 2'd0, 13'd58);       // interleaved bit set
    step();
    check("lmr_interleaved", err_cmd, 16'h1);
    drive(C_LMR, 2'd0, 13'd50);       // CL 3, BL 4
    step();
    check("lmr_50", err_cmd, 16'h0);
    nops(1);

    // Bank 0: ACTIVE, ACTIVE again (illegal), then auto-precharge WRITE.
    drive(C_ACT, 2'd0, 13'h0);
    step();
    check("act_b0", err_cmd, 16'h0);
    drive(C_ACT, 2'd0, 13'h0);
    step();
    check("act_on_active", err_cmd, 16'h1);
    nops(1);
    write_burst(2'd0, 5'd0, 1'b1, 16'h0100, 16'h0101, 16'h0102, 16'h0103, 1'b1);
    drive(C_ACT, 2'd0, 13'h0);        // edge after the last beat: bank is IDLE
    step();
    check("act_after_ap_write", err_cmd, 16'h0);
    drive(C_PRE, 2'd0, 13'h0);
    step();
    nops(1);

    for (int b = 1; b < 4; b++) begin
      drive(C_ACT, 2'(b), 13'h0);
      step();
      check("act_wr_phase", err_cmd, 16'h0);
      nops(2);
      write_burst(2'(b), 5'd0, 1'b1, 16'((b + 1) * 256), 16'((b + 1) * 256 + 1),
                  16'((b + 1) * 256 + 2), 16'((b + 1) * 256 + 3), 1'b0);
      nops(1);
    end

    for (int b = 0; b < 4; b++) begin
      drive(C_ACT, 2'(b), 13'h0);
      step();
      check("act_rd_phase", err_cmd, 16'h0);
      nops(2);
      read_burst(2'(b), 5'd0, 1'b1, 16'((b + 1) * 256), 16'((b + 1) * 256 + 1),
                 16'((b + 1) * 256 + 2), 16'((b + 1) * 256 + 3), 1'b0, 1'b0);
    end

    // Column wrap: WRITE at col 6 lands at 6, 7, 4, 5.
    drive(C_ACT, 2'd0, 13'h0);
    step();
    check("act_wrap", err_cmd, 16'h0);
    nops(2);
    write_burst(2'd0, 5'd6, 1'b0, 16'hBEE0, 16'hBEE1, 16'hBEE2, 16'hBEE3, 1'b0);
    read_burst(2'd0, 5'd6, 1'b0, 16'hBEE0, 16'hBEE1, 16'hBEE2, 16'hBEE3, 1'b0, 1'b0);
    read_burst(2'd0, 5'd4, 1'b1, 16'hBEE2, 16'hBEE3, 16'hBEE0, 16'hBEE1, 1'b1, 1'b0);

    // READ one cycle after ACTIVE: a timing violation when checking is built
    // in, but the data is returned either way.
    nops(2);
    drive(C_ACT, 2'd1, 13'h0);
    step();
    check("act_trcd", err_cmd, 16'h0);
    read_burst(2'd1, 5'd0, 1'b1, 16'h0200, 16'h0201, 16'h0202, 16'h0203, 1'b0, TIMING_EN);

    nops(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_cmd_responder.md
Name: sdram_cmd_responder

Overview:
Synthesizable single-chip SDRAM device-side responder. It decodes the controller's command bus (CS#/RAS#/CAS#/WE#), tracks per-bank row state, holds the mode register and services burst reads and writes into a small on-chip array. It is the device end of the x16 SDRAM command interface that our controllers and directed benches drive. It is used as an FPGA-resident memory stand-in and as a protocol checker.

Parameters:
ROW_BITS, 3, stored row bits per bank (addr[ROW_BITS-1:0] at ACTIVE).
COL_BITS, 5, stored column bits (addr[COL_BITS-1:0] at READ/WRITE; COL_BITS ≥ 3).
TRCD, 3, minimum cycles from ACTIVE to READ/WRITE on the same bank.
TRP, 2, minimum cycles from PRECHARGE to ACTIVE on the same bank.
TRFC, 9, minimum cycles from AUTO REFRESH to any non-NOP command.

Ports:
clk  in  1  clock; all sampling on the rising edge.
rst  in  1  synchronous, active-high reset.
cke  in  1  clock enable; when low, command and data inputs are ignored and no state advances.
cs_n  in  1  chip select, active low.
ras_n  in  1  row strobe.
cas_n  in  1  column strobe.
we_n  in  1  write enable.
ba  in  2  bank address.
addr  in  13  row / column / opcode; A10 = auto-precharge / precharge-all.
dqm  in  2  byte mask; bit0 = dq[7:0], bit1 = dq[15:8].
dq_in  in  16  write data.
dq_out  out  16  read data (registered).
dq_oe  out  1  read data valid / drive enable (registered).
err_cmd  out  1  one-cycle pulse on an illegal command.
err_timing  out  1  one-cycle pulse on a timing violation (see Optional Feature).

Behaviour:
- Reset state: dq_out = 0, dq_oe = 0, err_cmd = 0, err_timing = 0, all banks IDLE, mode_valid = 0, burst generator IDLE, read delay line empty. Array contents are not reset.
- Command decode, only when cke = 1 and cs_n = 0, on {ras_n, cas_n, we_n}:
  - 111 NOP
  - 011 ACTIVE
  - 101 READ
  - 100 WRITE
  - 010 PRECHARGE
  - 001 AUTO REFRESH
  - 000 LOAD MODE
  - 110 BURST TERMINATE
- cs_n = 1 is a NOP.
- LOAD MODE: legal only when all banks are IDLE, otherwise err_cmd. Fields:
  - addr[2:0] BL: 0→1, 1→2, 2→4, 3→8; others → err_cmd and the register is unchanged.
  - addr[3] must be 0 (sequential only); 1 → err_cmd.
  - addr[6:4] CL: only 2 or 3 accepted, else err_cmd.
  - A successful load sets mode_valid = 1. Example: opcode 50 gives CL = 3, BL = 4.
- Bank FSM, per bank, IDLE ↔ ACTIVE:
  - ACTIVE on an IDLE bank latches the row and moves it to ACTIVE. ACTIVE on an ACTIVE bank → err_cmd, no change.
  - PRECHARGE with A10 = 1 idles all banks; with A10 = 0 it idles bank ba. Precharging an IDLE bank is legal.
- READ/WRITE:
  - Illegal when mode_valid = 0 or the target bank is IDLE → err_cmd, command ignored.
  - Column = addr[COL_BITS-1:0]; A10 = auto-precharge.
- Burst generator, states IDLE / WR / RD:
  - Beat k addresses column {col[COL_BITS-1:b], (col[b-1:0] + k) mod BL}, where b = log2(BL). This is a sequential wrap within the BL-aligned block.
  - WRITE: beat 0 is dq_in at the command edge; beats 1..BL-1 are taken on the following edges. A byte is written only where its dqm bit = 0 on that same edge.
  - READ: each beat pushes {valid, address} into a CL-1 deep delay line. Data for a READ sampled at edge N appears on dq_out with dq_oe = 1 after edge N+CL-1, so the controller samples it at edge N+CL. Consecutive beats occupy consecutive cycles.
  - Read DQM latency is 2: dqm sampled at edge M forces dq_oe = 0 for the beat sampled at edge M+2.
- Interruption rules:
  - A new READ/WRITE restarts the generator; beats already in the delay line still drain.
  - WRITE flushes the delay line: dq_oe = 0 from the next cycle.
  - BURST TERMINATE returns the generator to IDLE.
  - PRECHARGE of the bursting bank terminates the burst.
- Auto-precharge: the bank goes IDLE on the edge after its last generated beat. If the burst is interrupted, the bank goes IDLE at the interruption.
- AUTO REFRESH with any bank ACTIVE → err_cmd and is ignored; otherwise it is a no-op for the array.
- Simultaneous events: rst overrides everything. When cke = 0 for a cycle, the generator and delay line hold.

Optional Feature:
SDRAM_TIMING_CHECK_EN:
- Defined: per-bank counters enforce TRCD (ACTIVE→READ/WRITE), TRP (PRECHARGE→ACTIVE) and TRFC (REFRESH→next non-NOP command). Cycle counts are measured in cke = 1 edges.
- A violation pulses err_timing for one cycle. The command is still executed.
- Undefined: no counters are instantiated and err_timing is tied to 0.

Test Plan:
- Init: 10 NOP, PRECHARGE A10 = 1, 4 NOP, REFRESH, 9 NOP, REFRESH, 9 NOP, LOAD MODE 50 → no err_cmd pulse; CL = 3, BL = 4.
- Per bank 0..3: ACTIVE row 0, 2 NOP, WRITE col 0 A10 = 1 with data 100..103 (bank 1: 200.., bank 2: 300.., bank 3: 400..) → bank returns IDLE after beat 3.
- For each bank: ACTIVE, 2 NOP, READ col 0 A10 = 1 → dq_oe high for exactly 4 cycles starting 3 edges after READ, carrying that bank's 100..103 / 200..203 / 300..303 / 400..403.
- WRITE at col 6 with BL = 4 → data lands at columns 6, 7, 4, 5. Read back with dqm = 01 on the edge after READ → beat 1 has dq_oe = 0.
- READ before LOAD MODE, and ACTIVE to an already ACTIVE bank → err_cmd pulses once each.
- SDRAM_TIMING_CHECK_EN: ACTIVE followed by READ one cycle later → err_timing pulses once and data is still returned.
